// File: rtl/rr_mux_nx1_if.sv
// Handshake bundle for rr_mux_nx1: N_CH producer channels in, one registered stream out.
// slave is the mux's view, master is the producer/consumer side.
interface rr_mux_nx1_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_nx1.sv
// Registered N-to-1 round-robin stream multiplexer with single-entry output register.
// Optional macro RR_MUX_PRIO0_EN makes channel 0 strict-priority over the round-robin set.
module rr_mux_nx1 #(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input logic        clk,
    input logic        rst_n,
    rr_mux_nx1_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0]  last_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  cand;
    logic              rr_found;
    logic [SEL_W-1:0]  grant_idx;
    logic [N_CH-1:0]   rr_valid;
    logic [N_CH-1:0]   ready;
    logic              any_valid;
    logic              can_load;
    logic              load;

    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              valid_q;

    // Wrap by explicit compare so non-power-of-two N_CH never yields an index >= N_CH.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign any_valid = |bus.in_valid;

`ifdef RR_MUX_PRIO0_EN
    // Channel 0 is outside the rotation; it preempts whenever valid.
    assign rr_valid  = {bus.in_valid[N_CH-1:1], 1'b0};
    assign grant_idx = bus.in_valid[0] ? '0 : rr_idx;
`else
    assign rr_valid  = bus.in_valid;
    assign grant_idx = rr_idx;
`endif

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = next_idx(last_grant);
        for (int k = 0; k < N_CH; k++) begin
            if (!rr_found && rr_valid[cand]) begin
                rr_idx   = cand;
                rr_found = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

    assign can_load = !valid_q || bus.out_ready;
    assign load     = can_load && any_valid;

    always_comb begin
        ready = '0;
        if (load) begin
            ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            sel_q      <= '0;
            last_grant <= LAST_IDX;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= bus.in_data[grant_idx*DATA_W +: DATA_W];
            sel_q   <= grant_idx;
`ifdef RR_MUX_PRIO0_EN
            if (grant_idx != '0) begin
                last_grant <= grant_idx;
            end
`else
            last_grant <= grant_idx;
`endif
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule
